// File: rtl/spi_rx_mux.sv
// rtl/spi_rx_mux.sv - N-channel SPI mode-0 slave receivers merged into one round-robin word stream
// Each channel has its own synchroniser, shift register, FIFO and MISO echo of the last received word.
module spi_rx_mux #(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              sysclk,
  input  logic              rstn,
  input  logic [N_CH-1:0]   SCLK,
  input  logic [N_CH-1:0]   MOSI,
  input  logic [N_CH-1:0]   CS_n,
  output logic [N_CH-1:0]   MISO,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [N_CH-1:0]   ovf,
  input  logic [N_CH-1:0]   ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);

  logic [N_CH-1:0]   wr_req;
  logic [N_CH-1:0]   pop;
  logic [N_CH-1:0]   sel_off;
  logic [N_CH-1:0]   avail;
  logic [DATA_W-1:0] wr_word   [N_CH];
  logic [DATA_W-1:0] cand_data [N_CH];

  logic              load;
  logic              found;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   last_gnt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [2:0]        sclk_q;
    logic [2:0]        cs_q;
    logic [1:0]        mosi_q;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-2:0] shreg;
    logic [DATA_W-1:0] last_word;
    logic [DATA_W-1:0] miso_sh;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_sel;
    logic              cs_fall;
    logic [AW:0]       wp;
    logic [AW:0]       rp;
    logic [AW:0]       cnt;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              full;
    logic              wr_ok;
    logic              ovf_r;

    // [1] is the synchronised value, [2] its previous cycle for edge detection
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_sel    = ~cs_q[1];
    assign cs_fall   = ~cs_q[1] & cs_q[2];

    assign wr_word[g] = {shreg, mosi_q[1]};
    assign wr_req[g]  = cs_sel & sclk_rise & (bit_cnt == BW'(DATA_W - 1));
    assign MISO[g]    = miso_sh[DATA_W-1];

    always_ff @(posedge sysclk or negedge rstn) begin
      if (!rstn) begin
        sclk_q    <= '0;
        cs_q      <= '0;
        mosi_q    <= '0;
        bit_cnt   <= '0;
        shreg     <= '0;
        last_word <= '0;
        miso_sh   <= '0;
      end else begin
        sclk_q <= {sclk_q[1:0], SCLK[g]};
        cs_q   <= {cs_q[1:0], CS_n[g]};
        mosi_q <= {mosi_q[0], MOSI[g]};
        if (!cs_sel) begin
          bit_cnt <= '0;
        end else if (sclk_rise) begin
          shreg   <= wr_word[g][DATA_W-2:0];
          bit_cnt <= wr_req[g] ? '0 : bit_cnt + 1'b1;
        end
        if (wr_req[g]) last_word <= wr_word[g];
        if (cs_fall) miso_sh <= last_word;
        else if (cs_sel && sclk_fall) miso_sh <= {miso_sh[DATA_W-2:0], 1'b0};
      end
    end

    // The word on the output register stays in its FIFO until handshaken,
    // so candidates skip it via sel_off and capacity stays FIFO_DEPTH.
    assign cnt          = wp - rp;
    assign full         = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign sel_off[g]   = out_valid & (out_ch == CH_W'(g));
    assign avail[g]     = cnt > (AW+1)'(sel_off[g]);
    assign cand_data[g] = mem[rp[AW-1:0] + AW'(sel_off[g])];
    assign pop[g]       = out_valid & out_ready & (out_ch == CH_W'(g));
    assign wr_ok        = wr_req[g] & (~full | pop[g]);
    assign ovf[g]       = ovf_r;

    always_ff @(posedge sysclk) begin
      if (wr_ok) mem[wp[AW-1:0]] <= wr_word[g];
    end

    always_ff @(posedge sysclk or negedge rstn) begin
      if (!rstn) begin
        wp    <= '0;
        rp    <= '0;
        ovf_r <= 1'b0;
      end else begin
        if (wr_ok) wp <= wp + 1'b1;
        if (pop[g]) rp <= rp + 1'b1;
        if (wr_req[g] && !wr_ok) ovf_r <= 1'b1;
        else if (ovf_clr[g]) ovf_r <= 1'b0;
      end
    end
  end

  assign load = ~out_valid | out_ready;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(last_gnt) + 1 + k) % N_CH;
      if (!found && avail[idx]) begin
        found = 1'b1;
        gnt   = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last_gnt  <= CH_W'(N_CH - 1);
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_data <= cand_data[gnt];
        out_ch   <= gnt;
        last_gnt <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_mux.sv
// tb/tb_spi_rx_mux.sv - self-checking bench for spi_rx_mux
module tb_spi_rx_mux;
  localparam int N_CH = 4;
  localparam int DATA_W = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W = 2;
  localparam int HALF = 4;

  logic              sysclk = 1'b0;
  logic              rstn = 1'b0;
  logic [N_CH-1:0]   SCLK = '0;
  logic [N_CH-1:0]   MOSI = '0;
  logic [N_CH-1:0]   CS_n = '1;
  logic [N_CH-1:0]   MISO;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic [N_CH-1:0]   ovf;
  logic [N_CH-1:0]   ovf_clr = '0;

  spi_rx_mux #(.N_CH(N_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .sysclk(sysclk), .rstn(rstn), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n), .MISO(MISO),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  logic force_ready = 1'b0;

  int                got_ch[$];
  logic [DATA_W-1:0] got_data[$];
  int                got_cyc[$];
  logic [DATA_W-1:0] exp_q[N_CH][$];
  logic [DATA_W-1:0] tx_word[N_CH];
  logic [DATA_W-1:0] miso_cap[N_CH];

  bit                stall = 1'b0;
  logic [DATA_W-1:0] stall_data;
  logic [CH_W-1:0]   stall_ch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge sysclk) begin
    cyc++;
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
  end

  always @(negedge sysclk) begin
    if (!rstn) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(stall_data));
        check("hold_ch", 32'(out_ch), 32'(stall_ch));
      end
      if (out_valid && out_ready) begin
        got_ch.push_back(int'(out_ch));
        got_data.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      stall      = out_valid && !out_ready;
      stall_data = out_data;
      stall_ch   = out_ch;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic clear_got();
    got_ch.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  // Clocks nbits MSB-first bits of tx_word on all channels in mask; with lat set,
  // checks output timing around the last rising SCLK edge.
  task automatic send_frame(input logic [N_CH-1:0] mask, input int nbits, input bit lat);
    CS_n = CS_n & ~mask;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (mask[c]) begin
          miso_cap[c][DATA_W-1-i] = MISO[c];
          MOSI[c] = tx_word[c][DATA_W-1-i];
        end
      end
      tick(1);
      SCLK = SCLK | mask;
      if (lat && i == nbits - 1) begin
        tick(3);
        check("lat_early", 32'(out_valid), 32'd0);
        tick(1);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h A5);
        check("lat_ch", 32'(out_ch), 32'd0);
      end else begin
        tick(HALF);
      end
      SCLK = SCLK & ~mask;
      tick(HALF);
    end
    CS_n = CS_n | mask;
    MOSI = MOSI & ~mask;
    tick(HALF);
  endtask

  initial begin
    int total;
    logic [N_CH-1:0] mask;
    tick(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_miso", 32'(MISO), 32'd0);
    rstn = 1'b1;
    force_ready = 1'b1;
    tick(2);

    // single word latency on ch0
    tx_word[0] = 8'h A5;
    send_frame(4'b0001, DATA_W, 1'b1);
    tick(5);
    check("single_cnt", 32'(got_data.size()), 32'd1);
    if (got_data.size() >= 1) begin
      check("single_data", 32'(got_data[0]), 32'h A5);
      check("single_ch", 32'(got_ch[0]), 32'd0);
    end
    clear_got();

    // round robin: last grant 0, so ch1 before ch3
    tx_word[1] = 8'h 11;
    tx_word[3] = 8'h 33;
    send_frame(4'b1010, DATA_W, 1'b0);
    tick(5);
    check("rr1_cnt", 32'(got_data.size()), 32'd2);
    if (got_data.size() >= 2) begin
      check("rr1_d0", 32'(got_data[0]), 32'h 11);
      check("rr1_c0", 32'(got_ch[0]), 32'd1);
      check("rr1_d1", 32'(got_data[1]), 32'h 33);
      check("rr1_c1", 32'(got_ch[1]), 32'd3);
      check("rr1_b2b", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
    end
    clear_got();
    tx_word[1] = 8'h 22;
    send_frame(4'b0010, DATA_W, 1'b0);
    tick(5);
    check("rr_mid_cnt", 32'(got_data.size()), 32'd1);
    clear_got();
    // last grant now 1, so ch3 wins the next simultaneous pair
    tx_word[1] = 8'h 44;
    tx_word[3] = 8'h 55;
    send_frame(4'b1010, DATA_W, 1'b0);
    tick(5);
    check("rr2_cnt", 32'(got_data.size()), 32'd2);
    if (got_data.size() >= 2) begin
      check("rr2_d0", 32'(got_data[0]), 32'h 55);
      check("rr2_c0", 32'(got_ch[0]), 32'd3);
      check("rr2_d1", 32'(got_data[1]), 32'h 44);
      check("rr2_c1", 32'(got_ch[1]), 32'd1);
      check("rr2_b2b", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
    end
    clear_got();

    // overflow: five words into a four-deep channel with no downstream accept
    force_ready = 1'b0;
    tick(2);
    for (int w = 0; w < 5; w++) begin
      tx_word[2] = 8'h 60 + 8'(w);
      send_frame(4'b0100, DATA_W, 1'b0);
    end
    check("ovf_set", 32'(ovf), 32'b0100);
    check("ovf_head", 32'(out_data), 32'h 60);
    check("ovf_head_ch", 32'(out_ch), 32'd2);
    force_ready = 1'b1;
    tick(10);
    check("ovf_cnt", 32'(got_data.size()), 32'd4);
    for (int k = 0; k < 4 && k < got_data.size(); k++) begin
      check("ovf_data", 32'(got_data[k]), 32'h 60 + 32'(k));
      check("ovf_ch", 32'(got_ch[k]), 32'd2);
    end
    ovf_clr = 4'b0100;
    tick(1);
    ovf_clr = '0;
    check("ovf_clr", 32'(ovf), 32'd0);
    clear_got();

    // partial word discarded at CS_n rise
    tx_word[0] = 8'h FF;
    send_frame(4'b0001, 5, 1'b0);
    tx_word[0] = 8'h 3C;
    send_frame(4'b0001, DATA_W, 1'b0);
    tick(5);
    check("part_cnt", 32'(got_data.size()), 32'd1);
    if (got_data.size() >= 1) check("part_data", 32'(got_data[0]), 32'h 3C);
    clear_got();

    // MISO echoes the previous word in the next frame
    tx_word[0] = 8'h 5A;
    send_frame(4'b0001, DATA_W, 1'b0);
    tx_word[0] = 8'h 00;
    send_frame(4'b0001, DATA_W, 1'b0);
    check("miso_echo", 32'(miso_cap[0]), 32'h 5A);
    tick(5);
    clear_got();

    // reset mid-stream aborts queued words
    force_ready = 1'b0;
    tx_word[0] = 8'h 71;
    tx_word[1] = 8'h 72;
    tx_word[2] = 8'h 73;
    send_frame(4'b0111, DATA_W, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_miso", 32'(MISO), 32'd0);
    tick(2);
    rstn = 1'b1;
    force_ready = 1'b1;
    tick(60);
    check("post_rst_cnt", 32'(got_data.size()), 32'd0);
    clear_got();

    // randomized traffic against per-channel ordered queues
    total = 0;
    rand_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int c = 0; c < N_CH; c++) begin
        tx_word[c] = 8'($urandom);
        if (mask[c]) begin
          exp_q[c].push_back(tx_word[c]);
          total++;
        end
      end
      send_frame(mask, DATA_W, 1'b0);
    end
    rand_ready = 1'b0;
    force_ready = 1'b1;
    for (int t = 0; t < 500 && got_data.size() < total; t++) tick(1);
    check("rand_cnt", 32'(got_data.size()), 32'(total));
    for (int k = 0; k < got_data.size(); k++) begin
      if (exp_q[got_ch[k]].size() == 0) begin
        check("rand_extra", 32'(got_ch[k]), 32'hFFFF_FFFF);
      end else begin
        check("rand_data", 32'(got_data[k]), 32'(exp_q[got_ch[k]].pop_front()));
      end
    end
    check("rand_ovf", 32'(ovf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_rx_mux.md
SPI_RX_MUX -- requirements
Module: spi_rx_mux

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of SPI slave channels, range 1..16.
REQ-002 SHALL have parameter DATA_W, default 8: bits per SPI word, range 4..32.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: words per channel FIFO, power of 2, minimum 2.
REQ-004 SHALL use derived width CH_W = max(1, clog2(N_CH)).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 sysclk  in  1  system clock; all state updates on its rising edge.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 SCLK  in  N_CH  per-channel SPI clock, asynchronous to sysclk.
REQ-009 MOSI  in  N_CH  per-channel SPI data in, asynchronous.
REQ-010 CS_n  in  N_CH  per-channel active-low chip select, asynchronous.
REQ-011 MISO  out  N_CH  per-channel SPI data out.
REQ-012 out_valid  out  1  merged word stream valid.
REQ-013 out_ready  in  1  downstream accept.
REQ-014 out_data  out  DATA_W  received word.
REQ-015 out_ch  out  CH_W  source channel index of out_data.
REQ-016 ovf  out  N_CH  sticky per-channel overflow flag.
REQ-017 ovf_clr  in  N_CH  per-channel overflow clear pulse.

Function
REQ-018 Each SCLK/MOSI/CS_n bit SHALL pass a 2-flop synchroniser; all edge detection SHALL use synchronised values (SPI mode 0).
REQ-019 A synchronised SCLK rising edge with synchronised CS_n=0 SHALL shift synchronised MOSI into the channel shift register, MSB first, and increment the bit counter.
REQ-020 When the bit counter reaches DATA_W on cycle T, the word SHALL be written to the channel FIFO at the end of T+1; the counter SHALL return to 0.
REQ-021 Synchronised CS_n high SHALL hold the bit counter at 0; a partial word at CS_n rise SHALL be discarded without a FIFO write.
REQ-022 A completed word arriving at a full channel FIFO SHALL be dropped and SHALL set ovf[ch]; FIFO contents are unchanged.
REQ-023 ovf[ch] SHALL clear on ovf_clr[ch]=1; if a drop occurs in the same cycle, set wins.
REQ-024 MISO[ch] SHALL shift out the last completed word of that channel (0 after reset), MSB first; load on synchronised CS_n falling edge, advance on synchronised SCLK falling edge; hold while CS_n high.
REQ-025 Output arbitration SHALL be round-robin over non-empty FIFOs, starting search at (last granted + 1) mod N_CH; after reset last granted = N_CH-1, so channel 0 has first priority.
REQ-026 out_valid/out_data/out_ch SHALL be registered; earliest out_valid=1 is cycle T+2 relative to REQ-020.
REQ-027 While out_valid=1 and out_ready=0, out_data and out_ch SHALL hold stable and no arbitration occurs.
REQ-028 A transfer occurs when out_valid=1 and out_ready=1; the next word (any channel) SHALL be presentable in the following cycle, sustaining one word per cycle.
REQ-029 Simultaneous FIFO write and read on one channel SHALL both succeed, including when full (read frees slot for the write) and when empty (no read).
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL use an extra pointer bit.

Reset
REQ-031 On rstn=0: out_valid=0, out_data=0, out_ch=0, ovf=0, MISO=0, all FIFOs empty, shift registers, bit counters and synchronisers cleared.
REQ-032 rstn assertion mid-word or mid-transfer SHALL abort everything immediately; no word is delivered after release until a complete new word is received.

Verification
REQ-033 Ch0 sends 0xA5 (DATA_W=8) -> single transfer out_data=0xA5, out_ch=0, out_valid first high 2 cycles after last-bit edge detect.
REQ-034 Ch1 and ch3 complete words 0x11 and 0x33 in the same cycle, out_ready=1 -> 0x11/ch1 then 0x33/ch3 on consecutive cycles; next simultaneous pair ch1+ch3 -> ch3 first.
REQ-035 Ch2 sends 5 words, out_ready=0, FIFO_DEPTH=4 -> ovf[2]=1, first 4 words delivered in order after out_ready=1, 5th lost; ovf_clr[2] pulse -> ovf[2]=0.
REQ-036 Ch0 sends 5 bits then CS_n rises, then full word 0x3C -> only 0x3C delivered.
REQ-037 Ch0 receives 0x5A, next CS_n frame -> MISO[0] shifts 0,1,0,1,1,0,1,0.
REQ-038 rstn pulsed low with 3 words queued and out_valid=1 -> out_valid=0 same cycle, no words delivered after release.
